// File: rtl/prbs_sched_pkg.sv
// ---------------------------------------------------------------------------
// prbs_sched_pkg
// Shared definitions for the TX PRBS frame scheduler: default field widths,
// the TX user-port data width, the full byte-lane-valid pattern and the
// scheduler state encoding.
// ---------------------------------------------------------------------------
package prbs_sched_pkg;

    localparam int FRAME_LEN_W_DEF = 16;
    localparam int GAP_W_DEF       = 8;
    localparam int CNT_W_DEF       = 32;

    localparam int         TX_DATA_W    = 32;
    localparam logic [1:0] TX_VLDB_FULL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/prbs_frame_sched.sv
// ---------------------------------------------------------------------------
// prbs_frame_sched
// Turns a free-running external PRBS31 word source into framed
// AXI-stream-style traffic for the TX MAC/PCS user port. A run is
// frame_num frames (0 = continuous) of frame_len+1 words each, separated by
// gap_len idle cycles. The external generator is advanced only on accepted
// beats (prbs_en_o), so the sequence continues across frames and runs.
//
// Optional feature: define PRBS_FRAME_SCHED_ERR_INJ_EN to enable single-bit
// error injection (bit 0 of the next accepted beat is inverted per request).
//
// Ports
//   tx_user_clk_i / tx_user_rst_i : clock, synchronous active-high reset
//   start_i, stop_i               : run start (IDLE only) / graceful stop
//   frame_len_i, gap_len_i,
//   frame_num_i                   : run configuration, latched on start
//   prbs_data_i, prbs_en_o        : external PRBS word and its advance strobe
//   tx_data_o, tx_vldb_o,
//   tx_valid_o, tx_ready_i,
//   tx_last_o, tx_user_o          : TX user stream
//   err_inj_i                     : error-injection request pulse
//   busy_o, done_o                : run active / one-cycle run-end pulse
//   frames_sent_o, words_sent_o,
//   err_cnt_o                     : saturating status counters
// ---------------------------------------------------------------------------
module prbs_frame_sched
    import prbs_sched_pkg::*;
#(
    parameter int FRAME_LEN_W = FRAME_LEN_W_DEF,
    parameter int GAP_W       = GAP_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   tx_user_clk_i,
    input  logic                   tx_user_rst_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [FRAME_LEN_W-1:0] frame_len_i,
    input  logic [GAP_W-1:0]       gap_len_i,
    input  logic [CNT_W-1:0]       frame_num_i,
    input  logic [TX_DATA_W-1:0]   prbs_data_i,
    output logic                   prbs_en_o,
    output logic [TX_DATA_W-1:0]   tx_data_o,
    output logic [1:0]             tx_vldb_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   tx_last_o,
    output logic                   tx_user_o,
    input  logic                   err_inj_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_W-1:0]       frames_sent_o,
    output logic [CNT_W-1:0]       words_sent_o,
    output logic [CNT_W-1:0]       err_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    sched_state_e           state_q, state_d;
    logic                   done_q, done_d;
    logic                   stop_pend_q;
    logic [FRAME_LEN_W-1:0] frame_len_q, word_cnt_q;
    logic [GAP_W-1:0]       gap_len_q, gap_cnt_q;
    logic [CNT_W-1:0]       frame_num_q;
    logic [CNT_W-1:0]       frames_sent_q, words_sent_q;

    logic                   hs, last_hs, stop_now, run_end, start_ok;
    logic [TX_DATA_W-1:0]   err_mask;

    // Stream outputs decode from registered state only; never from tx_ready_i.
    assign tx_valid_o = (state_q == SEND);
    assign tx_last_o  = tx_valid_o && (word_cnt_q == frame_len_q);
    assign tx_vldb_o  = tx_valid_o ? TX_VLDB_FULL : 2'b00;
    assign tx_user_o  = 1'b0;
    assign tx_data_o  = prbs_data_i ^ err_mask;

    assign hs        = tx_valid_o & tx_ready_i;
    assign prbs_en_o = hs;
    assign last_hs   = hs & tx_last_o;
    assign start_ok  = (state_q == IDLE) && start_i;

    // A stop arriving on the very cycle of the last handshake also ends the run.
    assign stop_now = stop_pend_q | stop_i;
    // Widened compare so a saturated frames_sent cannot wrap into a match.
    assign run_end  = (frame_num_q != '0) &&
                      (({1'b0, frames_sent_q} + (CNT_W+1)'(1)) == {1'b0, frame_num_q});

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign frames_sent_o = frames_sent_q;
    assign words_sent_o  = words_sent_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = SEND;
            end
            SEND: begin
                if (last_hs) begin
                    if (stop_now || run_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (gap_len_q != '0) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (stop_now) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == gap_len_q - GAP_W'(1)) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and status counters
    always_ff @(posedge tx_user_clk_i) begin
        if (tx_user_rst_i) begin
            state_q       <= IDLE;
            done_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
            word_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            frames_sent_q <= '0;
            words_sent_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (start_ok) begin
                stop_pend_q   <= 1'b0;
                word_cnt_q    <= '0;
                gap_cnt_q     <= '0;
                frames_sent_q <= '0;
                words_sent_q  <= '0;
            end else if (state_q != IDLE) begin
                if (hs) words_sent_q <= sat_inc(words_sent_q);
                if (last_hs) begin
                    frames_sent_q <= sat_inc(frames_sent_q);
                    word_cnt_q    <= '0;
                end else if (hs) begin
                    word_cnt_q <= word_cnt_q + FRAME_LEN_W'(1);
                end
                // Gap counter restarts on every entry into GAP.
                gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + GAP_W'(1) : '0;
                if (state_d == IDLE)
                    stop_pend_q <= 1'b0;
                else if (state_q == SEND && stop_i)
                    stop_pend_q <= 1'b1;
            end
        end
    end

    // Run configuration snapshot (data path, no reset needed)
    always_ff @(posedge tx_user_clk_i) begin
        if (start_ok) begin
            frame_len_q <= frame_len_i;
            gap_len_q   <= gap_len_i;
            frame_num_q <= frame_num_i;
        end
    end

`ifdef PRBS_FRAME_SCHED_ERR_INJ_EN
    logic             err_pend_q;
    logic [CNT_W-1:0] err_cnt_q;

    // Requests merge while pending; the flag drops on the beat that carries it.
    always_ff @(posedge tx_user_clk_i) begin
        if (tx_user_rst_i) begin
            err_pend_q <= 1'b0;
            err_cnt_q  <= '0;
        end else if (start_ok) begin
            err_pend_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (hs && err_pend_q) err_cnt_q <= sat_inc(err_cnt_q);
            err_pend_q <= (err_pend_q & ~hs) | err_inj_i;
        end
    end

    assign err_mask  = {{(TX_DATA_W-1){1'b0}}, err_pend_q & tx_valid_o};
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err_inj;
    assign unused_err_inj = err_inj_i;
    assign err_mask       = '0;
    assign err_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_prbs_frame_sched.sv
module tb_prbs_frame_sched;

    localparam logic [30:0] SEED = 31'h2A5C_1E37;

    logic        clk = 1'b0;
    logic        rst, start_i, stop_i, tx_ready_i, err_inj_i;
    logic [15:0] frame_len_i;
    logic [7:0]  gap_len_i;
    logic [31:0] frame_num_i;
    logic [31:0] prbs_data_i;
    logic        prbs_en_o, tx_valid_o, tx_last_o, tx_user_o, busy_o, done_o;
    logic [31:0] tx_data_o, frames_sent_o, words_sent_o, err_cnt_o;
    logic [1:0]  tx_vldb_o;

    always #5 clk = ~clk;

    prbs_frame_sched dut (
        .tx_user_clk_i(clk),        .tx_user_rst_i(rst),
        .start_i(start_i),          .stop_i(stop_i),
        .frame_len_i(frame_len_i),  .gap_len_i(gap_len_i),
        .frame_num_i(frame_num_i),  .prbs_data_i(prbs_data_i),
        .prbs_en_o(prbs_en_o),      .tx_data_o(tx_data_o),
        .tx_vldb_o(tx_vldb_o),      .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),    .tx_last_o(tx_last_o),
        .tx_user_o(tx_user_o),      .err_inj_i(err_inj_i),
        .busy_o(busy_o),            .done_o(done_o),
        .frames_sent_o(frames_sent_o), .words_sent_o(words_sent_o),
        .err_cnt_o(err_cnt_o)
    );

    // PRBS31 (x^31 + x^28 + 1), 32 bits per word.
    function automatic logic [31:0] prbs_word(input logic [30:0] s);
        logic [30:0] t = s;
        logic [31:0] w = '0;
        logic        nb;
        for (int i = 0; i < 32; i++) begin
            nb = t[30] ^ t[27];
            w  = {w[30:0], nb};
            t  = {t[29:0], nb};
        end
        return w;
    endfunction

    function automatic logic [30:0] prbs_adv(input logic [30:0] s);
        logic [30:0] t = s;
        logic        nb;
        for (int i = 0; i < 32; i++) begin
            nb = t[30] ^ t[27];
            t  = {t[29:0], nb};
        end
        return t;
    endfunction

    // External generator, advanced only by the DUT's prbs_en_o.
    logic        gen_run;
    logic [30:0] gen_s;
    always @(posedge clk) begin
        if (!gen_run)       gen_s <= SEED;
        else if (prbs_en_o) gen_s <= prbs_adv(gen_s);
    end
    assign prbs_data_i = prbs_word(gen_s);

    int checks = 0, failures = 0;
    logic [30:0] mdl_s;
    int n_valid, n_hs, n_last, n_en, n_done, since_last, cur_gap, flip_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        n_valid = 0; n_hs = 0; n_last = 0; n_en = 0; n_done = 0;
        since_last = -1;
    endtask

    task automatic observe();
        logic [31:0] exp;
        chk("vldb", 64'(tx_vldb_o), tx_valid_o ? 64'd3 : 64'd0);
        chk("prbs_en", 64'(prbs_en_o), 64'(tx_valid_o & tx_ready_i));
        if (tx_valid_o) n_valid++;
        if (prbs_en_o) n_en++;
        if (done_o) n_done++;
        if (since_last >= 0 && tx_valid_o) begin
            chk("gap_len", 64'(since_last), 64'(cur_gap));
            since_last = -1;
        end else if (since_last >= 0) begin
            since_last++;
        end
        if (tx_valid_o && tx_ready_i) begin
            exp = prbs_word(mdl_s);
            if (flip_beat != 0 && n_hs + 1 == flip_beat) exp[0] = ~exp[0];
            chk("data", 64'(tx_data_o), 64'(exp));
            mdl_s = prbs_adv(mdl_s);
            n_hs++;
            if (tx_last_o) begin
                n_last++;
                since_last = 0;
            end
        end
    endtask

    task automatic step();
        #2;
        observe();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] fl, input logic [7:0] gp, input logic [31:0] fn);
        frame_len_i = fl; gap_len_i = gp; frame_num_i = fn; cur_gap = int'(gp);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("valid_after_start", 64'(tx_valid_o), 64'd1);
    endtask

    task automatic run_to_done(input bit rmode, input int stop_at);
        int  cyc = 0;
        bit  stop_sent = 0;
        while (n_done == 0 && cyc < 400) begin
            tx_ready_i = rmode ? (cyc % 2 == 0) : 1'b1;
            stop_i = (stop_at != 0 && !stop_sent && tx_valid_o && n_hs + 1 == stop_at);
            if (stop_i) stop_sent = 1;
            step();
            cyc++;
        end
        stop_i = 1'b0;
        tx_ready_i = 1'b1;
        chk("done_seen", 64'(n_done), 64'd1);
    endtask

    task automatic quiet_after(input string tag);
        int nv = n_valid;
        repeat (5) step();
        chk({tag, "_no_valid_after"}, 64'(n_valid), 64'(nv));
        chk({tag, "_done_once"}, 64'(n_done), 64'd1);
        chk({tag, "_busy_idle"}, 64'(busy_o), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] flen;
        logic [7:0]  gap;
        logic [31:0] fnum;
        bit          rmode;
        int          stop_at;
        int          e_beats;
        int          e_lasts;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lim;
        bit pulsed;
        logic [31:0] exp_err;

        vecs[0] = '{"single",    16'd3, 8'd0, 32'd1, 1'b0, 0,  4, 1};
        vecs[1] = '{"gap_bp",    16'd7, 8'd5, 32'd3, 1'b1, 0, 24, 3};
        vecs[2] = '{"stop_mid",  16'd7, 8'd0, 32'd0, 1'b0, 2,  8, 1};
        vecs[3] = '{"short_gap", 16'd1, 8'd2, 32'd4, 1'b0, 0,  8, 4};
        vecs[4] = '{"one_word",  16'd0, 8'd0, 32'd5, 1'b1, 0,  5, 5};

        rst = 1'b1; start_i = 0; stop_i = 0; tx_ready_i = 1; err_inj_i = 0;
        frame_len_i = '0; gap_len_i = '0; frame_num_i = '0;
        gen_run = 1'b0; mdl_s = SEED; flip_beat = 0; cur_gap = 0;
        clear_obs();
        repeat (3) @(posedge clk);
        gen_run = 1'b1;
        @(negedge clk);

        chk("rst_valid", 64'(tx_valid_o), 0);
        chk("rst_last", 64'(tx_last_o), 0);
        chk("rst_vldb", 64'(tx_vldb_o), 0);
        chk("rst_prbs_en", 64'(prbs_en_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_done", 64'(done_o), 0);
        chk("rst_frames", 64'(frames_sent_o), 0);
        chk("rst_words", 64'(words_sent_o), 0);
        chk("rst_err", 64'(err_cnt_o), 0);
        chk("rst_user", 64'(tx_user_o), 0);
        chk("rst_data_follows", 64'(tx_data_o), 64'(prbs_word(gen_s)));
        rst = 1'b0;
        @(negedge clk);

        // Table-driven runs
        for (int i = 0; i < 5; i++) begin
            clear_obs();
            do_start(vecs[i].flen, vecs[i].gap, vecs[i].fnum);
            run_to_done(vecs[i].rmode, vecs[i].stop_at);
            chk({vecs[i].name, "_beats"}, 64'(n_hs), 64'(vecs[i].e_beats));
            chk({vecs[i].name, "_en_cnt"}, 64'(n_en), 64'(vecs[i].e_beats));
            chk({vecs[i].name, "_lasts"}, 64'(n_last), 64'(vecs[i].e_lasts));
            chk({vecs[i].name, "_frames_sent"}, 64'(frames_sent_o), 64'(vecs[i].e_lasts));
            chk({vecs[i].name, "_words_sent"}, 64'(words_sent_o), 64'(vecs[i].e_beats));
            chk({vecs[i].name, "_err_cnt"}, 64'(err_cnt_o), 0);
            quiet_after(vecs[i].name);
        end

        // Stop during a long gap
        clear_obs();
        do_start(16'd1, 8'd20, 32'd0);
        lim = 0;
        while (n_last < 1 && lim < 50) begin step(); lim++; end
        chk("gstop_first_last", 64'(n_last), 64'd1);
        step(); step();
        stop_i = 1'b1;
        chk("gstop_in_gap", 64'(tx_valid_o), 0);
        step();
        stop_i = 1'b0;
        chk("gstop_done_pulse", 64'(done_o), 1);
        chk("gstop_busy", 64'(busy_o), 0);
        repeat (25) step();
        chk("gstop_no_new_frame", 64'(n_valid), 64'd2);
        chk("gstop_done_once", 64'(n_done), 64'd1);
        chk("gstop_frames", 64'(frames_sent_o), 64'd1);
        chk("gstop_words", 64'(words_sent_o), 64'd2);

        // Reset during beat 5
        clear_obs();
        do_start(16'd7, 8'd0, 32'd0);
        lim = 0;
        while (n_hs < 4 && lim < 50) begin step(); lim++; end
        chk("rmid_reach_beat5", 64'(tx_valid_o), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmid_valid", 64'(tx_valid_o), 0);
        chk("rmid_last", 64'(tx_last_o), 0);
        chk("rmid_vldb", 64'(tx_vldb_o), 0);
        chk("rmid_en", 64'(prbs_en_o), 0);
        chk("rmid_busy", 64'(busy_o), 0);
        chk("rmid_frames", 64'(frames_sent_o), 0);
        chk("rmid_words", 64'(words_sent_o), 0);
        repeat (5) step();
        chk("rmid_no_done", 64'(n_done), 0);

        // Fresh run after reset; a start while busy must be ignored
        clear_obs();
        do_start(16'd3, 8'd0, 32'd1);
        lim = 0; pulsed = 0;
        while (n_done == 0 && lim < 100) begin
            if (!pulsed && n_hs == 2) begin
                start_i = 1'b1; frame_len_i = 16'd9; frame_num_i = 32'd0;
                pulsed = 1;
            end else begin
                start_i = 1'b0;
            end
            step();
            lim++;
        end
        start_i = 1'b0;
        chk("busy_start_done", 64'(n_done), 1);
        chk("busy_start_beats", 64'(n_hs), 4);
        chk("busy_start_lasts", 64'(n_last), 1);
        chk("busy_start_words", 64'(words_sent_o), 4);
        quiet_after("busy_start");

        // Error injection: two requests in the gap before beat 10
`ifdef PRBS_FRAME_SCHED_ERR_INJ_EN
        flip_beat = 10; exp_err = 32'd1;
`else
        flip_beat = 0;  exp_err = 32'd0;
`endif
        clear_obs();
        do_start(16'd8, 8'd4, 32'd2);
        lim = 0;
        while (n_last < 1 && lim < 50) begin step(); lim++; end
        err_inj_i = 1'b1; step();
        err_inj_i = 1'b0; step();
        err_inj_i = 1'b1; step();
        err_inj_i = 1'b0;
        run_to_done(1'b0, 0);
        chk("einj_beats", 64'(n_hs), 18);
        chk("einj_lasts", 64'(n_last), 2);
        chk("einj_err_cnt", 64'(err_cnt_o), 64'(exp_err));
        flip_beat = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
